// File: rtl/pll_reset_sequencer_if.sv
// Status and handshake bundle between the PLL reset sequencer and the logic it releases.
// The sequencer side takes the master modport; consumers and monitors take the slave modport.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       sys_rst_n;
    logic       ready;
    logic [2:0] state;
    logic [7:0] lock_loss_count;
    logic       status_led;

    modport master (
        input  pll_locked,
        output sys_rst_n,
        output ready,
        output state,
        output lock_loss_count,
        output status_led
    );

    modport slave (
        output pll_locked,
        input  sys_rst_n,
        input  ready,
        input  state,
        input  lock_loss_count,
        input  status_led
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Turns the raw PLL lock flag into a qualified sys_clk-domain reset/ready pair.
// Lock must hold for STABLE_CYCLES before release; repeated drops while stabilising latch FAULT.
module pll_reset_sequencer #(
    parameter int HOLD_CYCLES   = 256,
    parameter int STABLE_CYCLES = 1_800_000,
    parameter int RETRY_LIMIT   = 4,
    parameter int BLINK_DIV     = 90_000_000
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    pll_reset_sequencer_if.master seq
);
    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [31:0] HOLD_LAST        = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] STABLE_LAST      = 32'(STABLE_CYCLES - 1);
    localparam logic [31:0] RETRY_MAX        = 32'(RETRY_LIMIT);
    localparam logic [31:0] BLINK_LAST       = 32'(BLINK_DIV - 1);
    localparam logic [31:0] FAULT_BLINK_LAST = 32'(BLINK_DIV / 4 - 1);

    state_t      state_reg, state_next;
    logic [1:0]  sync_reg;
    logic        lk;
    logic [31:0] hold_cnt_reg, hold_cnt_next;
    logic [31:0] stab_cnt_reg, stab_cnt_next;
    logic [31:0] retry_cnt_reg, retry_cnt_next;
    logic [31:0] blink_cnt_reg, blink_cnt_next;
    logic [31:0] blink_limit;
    logic [7:0]  loss_cnt_reg, loss_cnt_next;
    logic        led_reg, led_next;
    logic        sys_rst_n_reg;
    logic        ready_reg;

    assign lk = sync_reg[1];

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg      <= 2'b00;
            state_reg     <= S_HOLD;
            hold_cnt_reg  <= 32'd0;
            stab_cnt_reg  <= 32'd0;
            retry_cnt_reg <= 32'd0;
            blink_cnt_reg <= 32'd0;
            loss_cnt_reg  <= 8'd0;
            led_reg       <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], seq.pll_locked};
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            stab_cnt_reg  <= stab_cnt_next;
            retry_cnt_reg <= retry_cnt_next;
            blink_cnt_reg <= blink_cnt_next;
            loss_cnt_reg  <= loss_cnt_next;
            led_reg       <= led_next;
            sys_rst_n_reg <= (state_next == S_RUN);
            ready_reg     <= (state_next == S_RUN);
        end
    end

    always_comb begin
        state_next     = state_reg;
        hold_cnt_next  = 32'd0;
        stab_cnt_next  = 32'd0;
        retry_cnt_next = retry_cnt_reg;
        loss_cnt_next  = loss_cnt_reg;
        case (state_reg)
            S_HOLD: begin
                if (hold_cnt_reg == HOLD_LAST) state_next = S_WAIT_LOCK;
                else                           hold_cnt_next = hold_cnt_reg + 32'd1;
            end
            S_WAIT_LOCK: begin
                if (lk) state_next = S_STABILIZE;
            end
            S_STABILIZE: begin
                if (lk) begin
                    if (stab_cnt_reg == STABLE_LAST) begin
                        state_next     = S_RUN;
                        retry_cnt_next = 32'd0;
                    end else begin
                        stab_cnt_next = stab_cnt_reg + 32'd1;
                    end
                end else begin
                    retry_cnt_next = retry_cnt_reg + 32'd1;
                    state_next     = (retry_cnt_next == RETRY_MAX) ? S_FAULT : S_WAIT_LOCK;
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_next = S_HOLD;
                    if (loss_cnt_reg != 8'hFF) loss_cnt_next = loss_cnt_reg + 8'd1;
                end
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: state_next = S_HOLD;
        endcase

        // Blink phase restarts on every state change; leaving RUN starts from LED off.
        led_next       = led_reg;
        blink_cnt_next = 32'd0;
        blink_limit    = (state_reg == S_FAULT) ? FAULT_BLINK_LAST : BLINK_LAST;
        if (state_next == S_RUN) begin
            led_next = 1'b0;
        end else if (state_next != state_reg) begin
            if (state_reg == S_RUN) led_next = 1'b1;
        end else if (blink_cnt_reg == blink_limit) begin
            led_next = ~led_reg;
        end else begin
            blink_cnt_next = blink_cnt_reg + 32'd1;
        end
    end

    assign seq.sys_rst_n       = sys_rst_n_reg;
    assign seq.ready           = ready_reg;
    assign seq.state           = state_reg;
    assign seq.lock_loss_count = loss_cnt_reg;
    assign seq.status_led      = led_reg;
endmodule
